// File: rtl/count_selector_pkg.sv
// count_selector_pkg
//   Shared definitions for the count selector and the blocks that sit next to
//   it on the counter boards (counter bank, display driver):
//     - default channel width, channel count and debounce length
//     - clog2_min1(): ceil(log2(n)) with a floor of 1, used for index and
//       counter widths so that a single-channel or single-cycle build still
//       gets a legal one-bit vector
//     - sel_src_e: which rule produced the next channel index
package count_selector_pkg;

  localparam int WIDTH_DEF     = 4;
  localparam int CHANNELS_DEF  = 4;
  localparam int DB_CYCLES_DEF = 16;

  typedef enum logic [1:0] {
    SRC_KEEP = 2'd0,
    SRC_LOAD = 2'd1,
    SRC_STEP = 2'd2
  } sel_src_e;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/count_selector_debounce.sv
// sw_debounce
//   Synchronises a raw, bouncing push button and filters it into a clean
//   level. A level change is accepted only after the synchronised input has
//   differed from the accepted level for DB_CYCLES consecutive clock edges;
//   any return to the accepted level restarts the count.
//
// Ports
//   CLK    in   clock, all state on the rising edge
//   RST    in   synchronous active-high reset
//   SW     in   raw asynchronous button, active high
//   LEVEL  out  debounced level
//   RISE   out  high during the cycle whose closing edge takes LEVEL 0->1,
//               so a consumer registering on that edge acts in step with
//               LEVEL
module sw_debounce
  import count_selector_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic SW,
  output logic LEVEL,
  output logic RISE
);

  localparam int                CNT_W    = clog2_min1(DB_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic             stable;
  logic [CNT_W-1:0] db_cnt;
  logic             differ;
  logic             mature;

  assign differ = (s2 != stable);
  assign mature = differ && (db_cnt == CNT_LAST);

  // stage: two-flop synchroniser followed by the stability counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      stable <= 1'b0;
      db_cnt <= '0;
    end else begin
      s1 <= SW;
      s2 <= s1;
      if (!differ) begin
        db_cnt <= '0;
      end else if (mature) begin
        stable <= s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign LEVEL = stable;
  assign RISE  = mature && s2 && !RST;

endmodule

// File: rtl/count_selector.sv
// count_selector
//   Registered N-channel count selector. A debounced front-panel button steps
//   the selected channel round-robin, LOAD jumps straight to a channel, and
//   HOLD freezes the displayed count while selection keeps moving.
//
// Ports
//   CLK       in   clock, all state on the rising edge
//   RST       in   synchronous active-high reset
//   SW        in   raw button, active high
//   LOAD      in   direct-select strobe
//   LOAD_SEL  in   channel index taken when LOAD=1 (ignored if out of range)
//   HOLD      in   1 freezes CNT
//   CNT_IN    in   packed channels, channel k at [k*WIDTH +: WIDTH]
//   CNT       out  registered value of the channel named by SEL
//   SEL       out  current channel index
//   CHG       out  one-cycle pulse after any edge that changed SEL
module count_selector
  import count_selector_pkg::*;
#(
  parameter  int WIDTH     = WIDTH_DEF,
  parameter  int CHANNELS  = CHANNELS_DEF,
  parameter  int DB_CYCLES = DB_CYCLES_DEF,
  localparam int SEL_W     = clog2_min1(CHANNELS)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      SW,
  input  logic                      LOAD,
  input  logic [SEL_W-1:0]          LOAD_SEL,
  input  logic                      HOLD,
  input  logic [CHANNELS*WIDTH-1:0] CNT_IN,
  output logic [WIDTH-1:0]          CNT,
  output logic [SEL_W-1:0]          SEL,
  output logic                      CHG
);

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(CHANNELS - 1);

  logic             sw_level;
  logic             sw_rise;
  logic             press;
  logic             load_ok;
  sel_src_e         sel_src;
  logic [SEL_W-1:0] sel_nxt;
  logic [WIDTH-1:0] slice;

  sw_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_debounce (
    .CLK   (CLK),
    .RST   (RST),
    .SW    (SW),
    .LEVEL (sw_level),
    .RISE  (sw_rise)
  );

  // Only a 0->1 transition of the clean level counts as a press.
  assign press = sw_rise && !sw_level;

  // A LOAD always owns the edge: an in-range index is taken, an out-of-range
  // one is dropped, and in both cases a press maturing at that edge is lost.
  always_comb begin
    load_ok = LOAD && (32'(LOAD_SEL) < CHANNELS);
    sel_src = SRC_KEEP;
    if (LOAD) begin
      if (load_ok) sel_src = SRC_LOAD;
    end else if (press) begin
      sel_src = SRC_STEP;
    end
  end

  always_comb begin
    sel_nxt = SEL;
    case (sel_src)
      SRC_LOAD: sel_nxt = LOAD_SEL;
      SRC_STEP: sel_nxt = (SEL == SEL_LAST) ? '0 : SEL + 1'b1;
      default:  sel_nxt = SEL;
    endcase
  end

  // Slice mux driven by the registered SEL, so CNT follows a new channel one
  // edge after SEL moves.
  always_comb begin
    slice = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (SEL == SEL_W'(k)) slice = CNT_IN[k*WIDTH +: WIDTH];
    end
  end

  // stage: channel index and change pulse
  always_ff @(posedge CLK) begin
    if (RST) begin
      SEL <= '0;
      CHG <= 1'b0;
    end else begin
      SEL <= sel_nxt;
      CHG <= (sel_nxt != SEL);
    end
  end

  // stage: output count register
  always_ff @(posedge CLK) begin
    if (RST) begin
      CNT <= '0;
    end else if (!HOLD) begin
      CNT <= slice;
    end
  end

endmodule

// File: tb/tb_count_selector.sv
module tb_count_selector;

  localparam int W  = 4;
  localparam int CH = 4;
  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst, sw, load, hold;
  logic [1:0]  lsel;
  logic [15:0] cin;
  logic [3:0]  cnt;
  logic [1:0]  sel;
  logic        chg;

  logic        sw3, load3, hold3;
  logic [1:0]  lsel3;
  logic [11:0] cin3;
  logic [3:0]  cnt3;
  logic [1:0]  sel3;
  logic        chg3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  count_selector #(.WIDTH(W), .CHANNELS(CH), .DB_CYCLES(DB)) dut (
    .CLK(clk), .RST(rst), .SW(sw), .LOAD(load), .LOAD_SEL(lsel), .HOLD(hold),
    .CNT_IN(cin), .CNT(cnt), .SEL(sel), .CHG(chg)
  );

  count_selector #(.WIDTH(W), .CHANNELS(3), .DB_CYCLES(DB)) dut3 (
    .CLK(clk), .RST(rst), .SW(sw3), .LOAD(load3), .LOAD_SEL(lsel3), .HOLD(hold3),
    .CNT_IN(cin3), .CNT(cnt3), .SEL(sel3), .CHG(chg3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle vectors: inputs applied before an edge, outputs expected after it.
  typedef struct {
    logic        rst, sw, load;
    logic [1:0]  lsel;
    logic        hold;
    logic [15:0] cin;
    logic [1:0]  esel;
    logic [3:0]  ecnt;
    logic        echg;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic s, input logic l, input logic [1:0] ls,
                              input logic h, input logic [15:0] ci, input logic [1:0] es,
                              input logic [3:0] ec, input logic eg);
    vec_t v;
    v.rst = r; v.sw = s; v.load = l; v.lsel = ls; v.hold = h; v.cin = ci;
    v.esel = es; v.ecnt = ec; v.echg = eg;
    return v;
  endfunction

  // Press helper: raise SW one edge before edge 1, expect the step exactly
  // DB+2 edges later, a single CHG cycle, then release SW long enough to settle.
  task automatic do_press(input logic [1:0] exp_sel, input logic [3:0] exp_cnt, input string tag);
    logic [1:0] s0;
    int hit;
    s0  = sel;
    hit = 0;
    sw  = 1'b1;
    for (int n = 1; n <= DB + 8; n++) begin
      @(posedge clk); #1;
      if (sel != s0) begin
        hit = n;
        break;
      end
    end
    check({tag, " latency"}, hit, DB + 2);
    check({tag, " sel"}, sel, exp_sel);
    check({tag, " chg high"}, chg, 1);
    @(posedge clk); #1;
    check({tag, " chg low"}, chg, 0);
    check({tag, " cnt"}, cnt, exp_cnt);
    check({tag, " sel kept"}, sel, exp_sel);
    sw = 1'b0;
    repeat (DB + 3) @(posedge clk);
    #1;
  endtask

  // Behavioural reference: SW samples in a short queue give the value seen two
  // edges late; a streak of differing samples of length DB flips the level.
  logic       m_stable;
  int         m_run;
  logic [1:0] m_sel;
  logic [3:0] m_cnt;
  logic       m_chg;
  logic       swq[$];

  task automatic model_step();
    logic       s2pre;
    logic       pr;
    logic [1:0] nxt;
    if (rst) begin
      swq.delete();
      m_stable = 1'b0; m_run = 0; m_sel = 2'd0; m_cnt = 4'd0; m_chg = 1'b0;
      return;
    end
    s2pre = (swq.size() >= 2) ? swq[0] : 1'b0;
    swq.push_back(sw);
    if (swq.size() > 2) void'(swq.pop_front());
    pr = 1'b0;
    if (s2pre != m_stable) begin
      m_run++;
      if (m_run == DB) begin
        m_stable = s2pre;
        m_run    = 0;
        pr       = s2pre;
      end
    end else begin
      m_run = 0;
    end
    if (!hold) m_cnt = cin[m_sel*W +: W];
    nxt = m_sel;
    if (load) begin
      if (int'(lsel) < CH) nxt = lsel;
    end else if (pr) begin
      nxt = 2'((int'(m_sel) + 1) % CH);
    end
    m_chg = (nxt != m_sel);
    m_sel = nxt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int sw_left;
    int cyc;
    rst = 1'b1; sw = 1'b1; load = 1'b0; lsel = 2'd0; hold = 1'b0; cin = 16'hDCBA;
    sw3 = 1'b0; load3 = 1'b0; lsel3 = 2'd0; hold3 = 1'b0; cin3 = 12'hCBA;

    // Reset with SW high, then a clean press maturing at edge DB+2.
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 1, 0, 0, 0, 16'hDCBA, 0, 4'h0, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 1, 0, 0, 0, 16'hDCBA, 0, 4'hA, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 16'hDCBA, 1, 4'hA, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 16'hDCBA, 1, 4'hB, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 16'hDCBA, 1, 4'hB, 0));
    for (int i = 0; i < 7; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 16'hDCBA, 1, 4'hB, 0));

    foreach (tbl[i]) begin
      rst = tbl[i].rst; sw = tbl[i].sw; load = tbl[i].load; lsel = tbl[i].lsel;
      hold = tbl[i].hold; cin = tbl[i].cin;
      @(posedge clk); #1;
      check($sformatf("vec%0d sel", i), sel, tbl[i].esel);
      check($sformatf("vec%0d cnt", i), cnt, tbl[i].ecnt);
      check($sformatf("vec%0d chg", i), chg, tbl[i].echg);
    end

    do_press(2'd2, 4'hC, "press2");
    do_press(2'd3, 4'hD, "press3");
    do_press(2'd0, 4'hA, "press_wrap");

    // Bounce: short high pulses never mature; the final steady high does.
    cyc = 0;
    while (cyc < 20) begin
      int h, l;
      h = int'($urandom_range(1, 3));
      l = int'($urandom_range(1, 2));
      sw = 1'b1;
      repeat (h) @(posedge clk);
      sw = 1'b0;
      repeat (l) @(posedge clk);
      cyc += h + l;
    end
    #1;
    check("bounce no step", sel, 0);
    do_press(2'd1, 4'hB, "bounce");

    // LOAD at the very edge a press matures: LOAD wins, press is dropped.
    sw = 1'b1;
    repeat (DB + 1) @(posedge clk);
    #1;
    load = 1'b1; lsel = 2'd3;
    @(posedge clk); #1;
    check("load+press sel", sel, 3);
    check("load+press chg", chg, 1);
    load = 1'b0;
    @(posedge clk); #1;
    check("load+press chg once", chg, 0);
    check("load+press sel kept", sel, 3);
    check("load+press cnt", cnt, 4'hD);
    sw = 1'b0;
    repeat (DB + 3) @(posedge clk);
    #1;
    check("load+press dropped", sel, 3);

    // LOAD to the current channel: no pulse.
    load = 1'b1; lsel = 2'd3;
    @(posedge clk); #1;
    check("load same sel", sel, 3);
    check("load same chg", chg, 0);
    load = 1'b0;

    // Three-channel build: index 3 is out of range and ignored.
    load3 = 1'b1; lsel3 = 2'd2;
    @(posedge clk); #1;
    check("ch3 load2 sel", sel3, 2);
    check("ch3 load2 chg", chg3, 1);
    lsel3 = 2'd3;
    @(posedge clk); #1;
    check("ch3 load3 sel", sel3, 2);
    check("ch3 load3 chg", chg3, 0);
    check("ch3 cnt", cnt3, 4'hC);
    load3 = 1'b0;

    // HOLD: CNT frozen at B while two presses move SEL 1 -> 3.
    load = 1'b1; lsel = 2'd1;
    @(posedge clk); #1;
    load = 1'b0;
    check("hold prep sel", sel, 1);
    @(posedge clk); #1;
    check("hold prep cnt", cnt, 4'hB);
    hold = 1'b1; cin = 16'h1234;
    do_press(2'd2, 4'hB, "hold1");
    do_press(2'd3, 4'hB, "hold2");
    hold = 1'b0;
    @(posedge clk); #1;
    check("unhold cnt", cnt, 4'h1);
    check("unhold sel", sel, 3);

    // Reset while the debounce counter sits at 2.
    cin = 16'hDCBA;
    sw = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst sel", sel, 0);
    check("midrst chg", chg, 0);
    check("midrst cnt", cnt, 0);
    rst = 1'b0;
    do_press(2'd1, 4'hB, "midrst");

    // Random phase against the reference model.
    sw_left = 0;
    for (int c = 0; c < 800; c++) begin
      if (sw_left == 0) begin
        sw = ~sw;
        sw_left = int'($urandom_range(1, 8));
      end
      sw_left--;
      rst  = (c < 2) || ($urandom_range(0, 99) == 0);
      load = ($urandom_range(0, 7) == 0);
      lsel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) hold = ~hold;
      cin  = 16'($urandom);
      model_step();
      @(posedge clk); #1;
      check($sformatf("rnd%0d sel", c), sel, m_sel);
      check($sformatf("rnd%0d cnt", c), cnt, m_cnt);
      check($sformatf("rnd%0d chg", c), chg, m_chg);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
